// File: rtl/instruction_decode.sv
// ID stage: register file, immediate generator, control decoder,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         pc_IFID,
  input  logic [WIDTH-1:0]         pc_4_IFID,
  input  logic [WIDTH-1:0]         instruction_IFID,
  input  logic                     flush,
  input  logic                     reg_wr_en_WBID,
  input  logic [$clog2(NREGS)-1:0] rd_WBID,
  input  logic [WIDTH-1:0]         wb_data_WBID,
  output logic                     stall,
  output logic [WIDTH-1:0]         pc_IDEX,
  output logic [WIDTH-1:0]         pc_4_IDEX,
  output logic [WIDTH-1:0]         rs1_data_IDEX,
  output logic [WIDTH-1:0]         rs2_data_IDEX,
  output logic [WIDTH-1:0]         imm_IDEX,
  output logic [$clog2(NREGS)-1:0] rs1_IDEX,
  output logic [$clog2(NREGS)-1:0] rs2_IDEX,
  output logic [$clog2(NREGS)-1:0] rd_IDEX,
  output logic [2:0]               funct3_IDEX,
  output logic [3:0]               alu_op_IDEX,
  output logic                     alu_a_sel_IDEX,
  output logic                     alu_b_sel_IDEX,
  output logic                     mem_read_IDEX,
  output logic                     mem_write_IDEX,
  output logic                     reg_wr_en_IDEX,
  output logic [1:0]               wb_sel_IDEX,
  output logic                     branch_IDEX,
  output logic                     jump_IDEX,
  output logic                     jalr_IDEX,
  output logic                     illegal_IDEX
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [WIDTH-1:0] r_regs [NREGS];

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_alt;
  logic [IDX_W-1:0] w_rs1, w_rs2, w_rd;
  logic [WIDTH-1:0] w_rs1_data, w_rs2_data, w_imm;
  logic [3:0]       w_alu_fn, w_alu_op;
  logic             w_a_sel, w_b_sel, w_mem_read, w_mem_write, w_reg_wr;
  logic [1:0]       w_wb_sel;
  logic             w_branch, w_jump, w_jalr, w_illegal;
  logic             w_rs1_used, w_rs2_used;

  assign w_opcode = instruction_IFID[6:0];
  assign w_funct3 = instruction_IFID[14:12];
  assign w_alt    = instruction_IFID[30];
  assign w_rd     = instruction_IFID[7 +: IDX_W];
  assign w_rs1    = instruction_IFID[15 +: IDX_W];
  assign w_rs2    = instruction_IFID[20 +: IDX_W];

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (reg_wr_en_WBID && (rd_WBID != '0)) begin
      r_regs[rd_WBID] <= wb_data_WBID;
    end
  end

  // Read ports with write-through bypass from WB; x0 reads zero.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != '0)
      w_rs1_data = (reg_wr_en_WBID && (rd_WBID == w_rs1)) ? wb_data_WBID : r_regs[w_rs1];
    if (w_rs2 != '0)
      w_rs2_data = (reg_wr_en_WBID && (rd_WBID == w_rs2)) ? wb_data_WBID : r_regs[w_rs2];
  end

  // ALU function from funct3; funct7[5] selects SRA over SRL.
  always_comb begin
    w_alu_fn = ALU_ADD;
    unique case (w_funct3)
      3'd0: w_alu_fn = ALU_ADD;
      3'd1: w_alu_fn = ALU_SLL;
      3'd2: w_alu_fn = ALU_SLT;
      3'd3: w_alu_fn = ALU_SLTU;
      3'd4: w_alu_fn = ALU_XOR;
      3'd5: w_alu_fn = w_alt ? ALU_SRA : ALU_SRL;
      3'd6: w_alu_fn = ALU_OR;
      3'd7: w_alu_fn = ALU_AND;
      default: w_alu_fn = ALU_ADD;
    endcase
  end

  // Main control decoder and immediate generator; opcode 0 with a zero word is a bubble.
  always_comb begin
    w_alu_op    = ALU_ADD;
    w_a_sel     = 1'b0;
    w_b_sel     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_wr    = 1'b0;
    w_wb_sel    = 2'd0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_jalr      = 1'b0;
    w_illegal   = 1'b0;
    w_imm       = '0;
    w_rs1_used  = 1'b1;
    w_rs2_used  = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_alu_op   = (w_funct3 == 3'd0 && w_alt) ? ALU_SUB : w_alu_fn;
        w_reg_wr   = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_IALU: begin
        w_imm    = {{(WIDTH-12){instruction_IFID[31]}}, instruction_IFID[31:20]};
        w_alu_op = w_alu_fn;
        w_b_sel  = 1'b1;
        w_reg_wr = 1'b1;
      end
      OP_LOAD: begin
        w_imm      = {{(WIDTH-12){instruction_IFID[31]}}, instruction_IFID[31:20]};
        w_b_sel    = 1'b1;
        w_mem_read = 1'b1;
        w_reg_wr   = 1'b1;
        w_wb_sel   = 2'd1;
      end
      OP_STORE: begin
        w_imm       = {{(WIDTH-12){instruction_IFID[31]}}, instruction_IFID[31:25], instruction_IFID[11:7]};
        w_b_sel     = 1'b1;
        w_mem_write = 1'b1;
        w_rs2_used  = 1'b1;
      end
      OP_BRANCH: begin
        w_imm      = {{(WIDTH-12){instruction_IFID[31]}}, instruction_IFID[7],
                      instruction_IFID[30:25], instruction_IFID[11:8], 1'b0};
        w_alu_op   = ALU_SUB;
        w_branch   = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_JAL: begin
        w_imm      = {{(WIDTH-20){instruction_IFID[31]}}, instruction_IFID[19:12],
                      instruction_IFID[20], instruction_IFID[30:21], 1'b0};
        w_a_sel    = 1'b1;
        w_b_sel    = 1'b1;
        w_jump     = 1'b1;
        w_reg_wr   = 1'b1;
        w_wb_sel   = 2'd2;
        w_rs1_used = 1'b0;
      end
      OP_JALR: begin
        w_imm    = {{(WIDTH-12){instruction_IFID[31]}}, instruction_IFID[31:20]};
        w_b_sel  = 1'b1;
        w_jalr   = 1'b1;
        w_reg_wr = 1'b1;
        w_wb_sel = 2'd2;
      end
      OP_LUI: begin
        w_imm      = {instruction_IFID[WIDTH-1:12], 12'b0};
        w_alu_op   = ALU_PASSB;
        w_b_sel    = 1'b1;
        w_reg_wr   = 1'b1;
        w_rs1_used = 1'b0;
      end
      OP_AUIPC: begin
        w_imm      = {instruction_IFID[WIDTH-1:12], 12'b0};
        w_a_sel    = 1'b1;
        w_b_sel    = 1'b1;
        w_reg_wr   = 1'b1;
        w_rs1_used = 1'b0;
      end
      default: w_illegal = (instruction_IFID != '0);
    endcase
  end

  // Load-use hazard against the load sitting in ID/EX; a flush cancels it.
  assign stall = mem_read_IDEX && (rd_IDEX != '0) && !flush &&
                 ((w_rs1_used && (rd_IDEX == w_rs1)) || (w_rs2_used && (rd_IDEX == w_rs2)));

  // ID/EX register: flush or stall inserts a bubble, otherwise capture the decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush || stall) begin
      pc_IDEX        <= '0;
      pc_4_IDEX      <= '0;
      rs1_data_IDEX  <= '0;
      rs2_data_IDEX  <= '0;
      imm_IDEX       <= '0;
      rs1_IDEX       <= '0;
      rs2_IDEX       <= '0;
      rd_IDEX        <= '0;
      funct3_IDEX    <= '0;
      alu_op_IDEX    <= '0;
      alu_a_sel_IDEX <= 1'b0;
      alu_b_sel_IDEX <= 1'b0;
      mem_read_IDEX  <= 1'b0;
      mem_write_IDEX <= 1'b0;
      reg_wr_en_IDEX <= 1'b0;
      wb_sel_IDEX    <= '0;
      branch_IDEX    <= 1'b0;
      jump_IDEX      <= 1'b0;
      jalr_IDEX      <= 1'b0;
      illegal_IDEX   <= 1'b0;
    end else begin
      pc_IDEX        <= pc_IFID;
      pc_4_IDEX      <= pc_4_IFID;
      rs1_data_IDEX  <= w_rs1_data;
      rs2_data_IDEX  <= w_rs2_data;
      imm_IDEX       <= w_imm;
      rs1_IDEX       <= w_rs1;
      rs2_IDEX       <= w_rs2;
      rd_IDEX        <= w_rd;
      funct3_IDEX    <= w_funct3;
      alu_op_IDEX    <= w_alu_op;
      alu_a_sel_IDEX <= w_a_sel;
      alu_b_sel_IDEX <= w_b_sel;
      mem_read_IDEX  <= w_mem_read;
      mem_write_IDEX <= w_mem_write;
      reg_wr_en_IDEX <= w_reg_wr;
      wb_sel_IDEX    <= w_wb_sel;
      branch_IDEX    <= w_branch;
      jump_IDEX      <= w_jump;
      jalr_IDEX      <= w_jalr;
      illegal_IDEX   <= w_illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: directed scenarios plus a randomized
// instruction stream checked against a behavioural ID-stage model.
module tb_instruction_decode;

  logic        clk, reset;
  logic [31:0] pc_IFID, pc_4_IFID, instruction_IFID;
  logic        flush, reg_wr_en_WBID;
  logic [4:0]  rd_WBID;
  logic [31:0] wb_data_WBID;
  logic        stall;
  logic [31:0] pc_IDEX, pc_4_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
  logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX;
  logic [2:0]  funct3_IDEX;
  logic [3:0]  alu_op_IDEX;
  logic        alu_a_sel_IDEX, alu_b_sel_IDEX, mem_read_IDEX, mem_write_IDEX, reg_wr_en_IDEX;
  logic [1:0]  wb_sel_IDEX;
  logic        branch_IDEX, jump_IDEX, jalr_IDEX, illegal_IDEX;

  instruction_decode #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .pc_IFID(pc_IFID), .pc_4_IFID(pc_4_IFID), .instruction_IFID(instruction_IFID),
    .flush(flush), .reg_wr_en_WBID(reg_wr_en_WBID), .rd_WBID(rd_WBID), .wb_data_WBID(wb_data_WBID),
    .stall(stall), .pc_IDEX(pc_IDEX), .pc_4_IDEX(pc_4_IDEX),
    .rs1_data_IDEX(rs1_data_IDEX), .rs2_data_IDEX(rs2_data_IDEX), .imm_IDEX(imm_IDEX),
    .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX), .funct3_IDEX(funct3_IDEX),
    .alu_op_IDEX(alu_op_IDEX), .alu_a_sel_IDEX(alu_a_sel_IDEX), .alu_b_sel_IDEX(alu_b_sel_IDEX),
    .mem_read_IDEX(mem_read_IDEX), .mem_write_IDEX(mem_write_IDEX), .reg_wr_en_IDEX(reg_wr_en_IDEX),
    .wb_sel_IDEX(wb_sel_IDEX), .branch_IDEX(branch_IDEX), .jump_IDEX(jump_IDEX),
    .jalr_IDEX(jalr_IDEX), .illegal_IDEX(illegal_IDEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  aluop;
    logic        asel, bsel, mr, mw, rwe;
    logic [1:0]  wbs;
    logic        br, j, jr, ill;
  } idex_t;

  int          n_checks = 0;
  int          n_errors = 0;
  string       phase = "reset";
  idex_t       m;
  logic [31:0] mregs [32];
  logic [31:0] pc_v = 32'h0;
  logic        last_stall = 1'b0;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s:%s got 0x%08h expected 0x%08h", phase, tag, got, exp);
    end
  endtask

  // Sign-extended immediates derived directly from the instruction formats.
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return 32'($signed(ins) >>> 20);
  endfunction

  function automatic logic [31:0] alu_code(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f3 == 3'd5 && alt) return 32'd7;
    if (f3 == 3'd0 && alt && is_r) return 32'd1;
    return 32'(tbl[f3]);
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] r, input logic wen,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (wen && wrd == r) return wd;
    return mregs[r];
  endfunction

  function automatic logic model_stall(input logic [31:0] ins, input logic fl);
    logic [6:0] op;
    logic u1, u2;
    op = ins[6:0];
    u1 = !(op inside {7'h37, 7'h17, 7'h6F});
    u2 = op inside {7'h33, 7'h23, 7'h63};
    return m.mr && (m.rd != 5'd0) && !fl &&
           ((u1 && m.rd == ins[19:15]) || (u2 && m.rd == ins[24:20]));
  endfunction

  function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
    idex_t d;
    d = '0;
    d.pc = pc; d.pc4 = pc + 32'd4; d.rs1d = a; d.rs2d = b;
    d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7]; d.f3 = ins[14:12];
    case (ins[6:0])
      7'h33: begin d.aluop = 4'(alu_code(ins[14:12], ins[30], 1'b1)); d.rwe = 1'b1; end
      7'h13: begin d.imm = imm_i(ins); d.aluop = 4'(alu_code(ins[14:12], ins[30], 1'b0));
                   d.bsel = 1'b1; d.rwe = 1'b1; end
      7'h03: begin d.imm = imm_i(ins); d.bsel = 1'b1; d.mr = 1'b1; d.rwe = 1'b1; d.wbs = 2'd1; end
      7'h23: begin d.imm = (imm_i(ins) & ~32'h1F) | 32'(ins[11:7]); d.bsel = 1'b1; d.mw = 1'b1; end
      7'h63: begin d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                   d.br = 1'b1; d.aluop = 4'd1; end
      7'h6F: begin d.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                   d.asel = 1'b1; d.bsel = 1'b1; d.j = 1'b1; d.wbs = 2'd2; d.rwe = 1'b1; end
      7'h67: begin d.imm = imm_i(ins); d.bsel = 1'b1; d.jr = 1'b1; d.wbs = 2'd2; d.rwe = 1'b1; end
      7'h37: begin d.imm = ins & 32'hFFFF_F000; d.aluop = 4'd10; d.bsel = 1'b1; d.rwe = 1'b1; end
      7'h17: begin d.imm = ins & 32'hFFFF_F000; d.asel = 1'b1; d.bsel = 1'b1; d.rwe = 1'b1; end
      default: d.ill = (ins != 32'd0);
    endcase
    return d;
  endfunction

  task automatic compare_idex();
    check("pc",     pc_IDEX, m.pc);
    check("pc4",    pc_4_IDEX, m.pc4);
    check("rs1d",   rs1_data_IDEX, m.rs1d);
    check("rs2d",   rs2_data_IDEX, m.rs2d);
    check("imm",    imm_IDEX, m.imm);
    check("rs1",    32'(rs1_IDEX), 32'(m.rs1));
    check("rs2",    32'(rs2_IDEX), 32'(m.rs2));
    check("rd",     32'(rd_IDEX), 32'(m.rd));
    check("funct3", 32'(funct3_IDEX), 32'(m.f3));
    check("alu_op", 32'(alu_op_IDEX), 32'(m.aluop));
    check("a_sel",  32'(alu_a_sel_IDEX), 32'(m.asel));
    check("b_sel",  32'(alu_b_sel_IDEX), 32'(m.bsel));
    check("mem_rd", 32'(mem_read_IDEX), 32'(m.mr));
    check("mem_wr", 32'(mem_write_IDEX), 32'(m.mw));
    check("reg_wr", 32'(reg_wr_en_IDEX), 32'(m.rwe));
    check("wb_sel", 32'(wb_sel_IDEX), 32'(m.wbs));
    check("branch", 32'(branch_IDEX), 32'(m.br));
    check("jump",   32'(jump_IDEX), 32'(m.j));
    check("jalr",   32'(jalr_IDEX), 32'(m.jr));
    check("illegal",32'(illegal_IDEX), 32'(m.ill));
  endtask

  // One pipeline cycle: present IF/ID and WB, check stall, then check ID/EX after the edge.
  task automatic cycle(input logic [31:0] ins, input logic fl, input logic wen,
                       input logic [4:0] wrd, input logic [31:0] wd);
    logic  es;
    idex_t nxt;
    @(negedge clk);
    pc_IFID = pc_v; pc_4_IFID = pc_v + 32'd4; instruction_IFID = ins;
    flush = fl; reg_wr_en_WBID = wen; rd_WBID = wrd; wb_data_WBID = wd;
    #1;
    es = model_stall(ins, fl);
    obs_stall = stall;
    check("stall", 32'(stall), 32'(es));
    if (fl || es) nxt = '0;
    else nxt = model_decode(ins, pc_v, rd_model(ins[19:15], wen, wrd, wd),
                            rd_model(ins[24:20], wen, wrd, wd));
    @(posedge clk);
    #1;
    if (wen && wrd != 5'd0) mregs[wrd] = wd;
    m = nxt;
    compare_idex();
    last_stall = es;
    if (!es) pc_v = pc_v + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2, 11: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;      7: op = 7'h37;
      8: op = 7'h17;  9: return 32'd0;
      default: case ($urandom_range(0, 3))
        0: op = 7'h7F; 1: op = 7'h0B; 2: op = 7'h5B; default: op = 7'h00;
      endcase
    endcase
    return {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12],
            5'($urandom_range(0, 7)), op} | ((op == 7'h00) ? 32'h0000_1000 : 32'h0);
  endfunction

  localparam logic [31:0] I_ADD_656 = 32'h0002_8333; // add x6,x5,x0
  localparam logic [31:0] I_ADDI_M1 = 32'hFFF0_0093; // addi x1,x0,-1
  localparam logic [31:0] I_SW      = 32'h0020_A423; // sw x2,8(x1)
  localparam logic [31:0] I_LW      = 32'h0000_A183; // lw x3,0(x1)
  localparam logic [31:0] I_ADD_433 = 32'h0031_8233; // add x4,x3,x3
  localparam logic [31:0] I_ADD_877 = 32'h0073_8433; // add x8,x7,x7
  localparam logic [31:0] I_ADD_900 = 32'h0000_04B3; // add x9,x0,x0
  localparam logic [31:0] I_JAL     = 32'h0100_00EF; // jal x1,16

  initial begin
    reset = 1'b0; flush = 1'b0; reg_wr_en_WBID = 1'b0; rd_WBID = '0; wb_data_WBID = '0;
    pc_IFID = '0; pc_4_IFID = '0; instruction_IFID = '0;
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

    @(negedge clk); @(negedge clk);
    #1;
    check("stall_rst", 32'(stall), 32'd0);
    compare_idex();
    @(negedge clk);
    reset = 1'b1;

    phase = "add";
    cycle(32'd0, 1'b0, 1'b1, 5'd5, 32'h1234);
    cycle(I_ADD_656, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_rs1d", rs1_data_IDEX, 32'h1234);
    check("k_rd", 32'(rd_IDEX), 32'd6);
    check("k_rwe", 32'(reg_wr_en_IDEX), 32'd1);

    phase = "imm";
    cycle(I_ADDI_M1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_imm", imm_IDEX, 32'hFFFF_FFFF);
    check("k_bsel", 32'(alu_b_sel_IDEX), 32'd1);
    cycle(I_SW, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_simm", imm_IDEX, 32'd8);
    check("k_mw", 32'(mem_write_IDEX), 32'd1);
    check("k_swrwe", 32'(reg_wr_en_IDEX), 32'd0);

    phase = "loaduse";
    cycle(I_LW, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(I_ADD_433, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_stall1", 32'(obs_stall), 32'd1);
    check("k_bubble", 32'(reg_wr_en_IDEX), 32'd0);
    cycle(I_ADD_433, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_stall2", 32'(obs_stall), 32'd0);
    check("k_rs1", 32'(rs1_IDEX), 32'd3);
    check("k_rs2", 32'(rs2_IDEX), 32'd3);

    phase = "bypass";
    cycle(I_ADD_877, 1'b0, 1'b1, 5'd7, 32'hAA);
    check("k_byp1", rs1_data_IDEX, 32'hAA);
    check("k_byp2", rs2_data_IDEX, 32'hAA);
    cycle(I_ADD_900, 1'b0, 1'b1, 5'd0, 32'h55);
    check("k_x0", rs1_data_IDEX, 32'd0);

    phase = "flush";
    cycle(I_JAL, 1'b1, 1'b0, 5'd0, 32'd0);
    check("k_fljump", 32'(jump_IDEX), 32'd0);
    cycle(I_LW, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(I_ADD_433, 1'b1, 1'b0, 5'd0, 32'd0);
    check("k_flstall", 32'(obs_stall), 32'd0);
    cycle(I_JAL, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_jimm", imm_IDEX, 32'd16);
    check("k_jump", 32'(jump_IDEX), 32'd1);
    check("k_jwb", 32'(wb_sel_IDEX), 32'd2);

    phase = "illegal";
    cycle(32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_ill", 32'(illegal_IDEX), 32'd1);
    check("k_illen", 32'({reg_wr_en_IDEX, mem_read_IDEX, mem_write_IDEX}), 32'd0);
    cycle(32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("k_nop", 32'(illegal_IDEX), 32'd0);

    phase = "rst_stall";
    cycle(I_LW, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    instruction_IFID = I_ADD_433; flush = 1'b0; reg_wr_en_WBID = 1'b0;
    #1;
    check("pre", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("drop", 32'(stall), 32'd0);
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    compare_idex();
    @(negedge clk);
    reset = 1'b1;
    last_stall = 1'b0;

    phase = "random";
    begin
      logic [31:0] ins;
      ins = 32'd0;
      for (int n = 0; n < 400; n++) begin
        logic fl;
        if (!last_stall) ins = rand_instr();
        fl = ($urandom_range(0, 9) == 0);
        if (fl) pc_v = $urandom & 32'hFFFF_FFFC;
        cycle(ins, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
